// File: rtl/pwm_duty_sequencer.sv
// pwm_duty_sequencer: debounced buttons or a triangular auto-sweep,
// turned into single-cycle duty step pulses for the PWM generator.
module pwm_duty_sequencer #(
    parameter int DB_CYCLES = 16,
    parameter int SWEEP_DIV = 1024,
    parameter int STEPS     = 10,
    parameter int SW        = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          btn_up,
    input  logic          btn_dn,
    input  logic          mode_auto,
    input  logic          run,
    input  logic [2:0]    conf_in,
    output logic          xu_o,
    output logic          xd_o,
    output logic          ena_o,
    output logic [2:0]    conf_o,
    output logic [SW-1:0] duty_step,
    output logic          sweep_dir
);
    localparam int CW = $clog2(DB_CYCLES);
    localparam int PW = $clog2(SWEEP_DIV);
    localparam logic [CW-1:0] DB_LAST  = CW'(DB_CYCLES - 1);
    localparam logic [PW-1:0] PS_LAST  = PW'(SWEEP_DIV - 1);
    localparam logic [SW-1:0] STEP_MAX = SW'(STEPS);

    typedef enum logic [1:0] {
        IDLE,
        RAMP_UP,
        RAMP_DN
    } state_t;

    state_t state_q, state_d;

    // bit 0 = up button, bit 1 = down button
    logic [1:0]         s1_q, s1_d;
    logic [1:0]         s2_q, s2_d;
    logic [1:0]         db_q, db_d;
    logic [1:0]         dbp_q, dbp_d;
    logic [1:0][CW-1:0] cnt_q, cnt_d;

    logic [PW-1:0] presc_q, presc_d;
    logic [SW-1:0] step_q, step_d;
    logic          xu_q, xu_d;
    logic          xd_q, xd_d;
    logic          ena_q, ena_d;
    logic [2:0]    conf_q, conf_d;

    logic req_up, req_dn;
    logic active, tick;
    logic at_max, at_min;

    always_comb begin
        s1_d  = {btn_dn, btn_up};
        s2_d  = s1_q;
        dbp_d = db_q;
        db_d  = db_q;
        cnt_d = cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (s2_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DB_LAST) begin
                db_d[i]  = s2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    assign req_up = db_q[0] & ~dbp_q[0];
    assign req_dn = db_q[1] & ~dbp_q[1];

    assign active = run & mode_auto;
    assign tick   = (state_q != IDLE) && (presc_q == PS_LAST);
    assign at_max = (step_q == STEP_MAX);
    assign at_min = (step_q == '0);

    always_comb begin
        state_d = state_q;
        if (!active) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = at_max ? RAMP_DN : RAMP_UP;
                RAMP_UP: if (tick && at_max) state_d = RAMP_DN;
                RAMP_DN: if (tick && at_min) state_d = RAMP_UP;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        sweep_dir = (state_q == RAMP_DN);
    end

    always_comb begin
        xu_d    = 1'b0;
        xd_d    = 1'b0;
        presc_d = '0;
        step_d  = step_q;
        if (active) begin
            if (state_q != IDLE) begin
                presc_d = tick ? '0 : presc_q + PW'(1);
            end
            if (tick) begin
                unique case (1'b1)
                    state_q == RAMP_UP && !at_max: xu_d = 1'b1;
                    state_q == RAMP_UP &&  at_max: xd_d = 1'b1;
                    state_q == RAMP_DN && !at_min: xd_d = 1'b1;
                    state_q == RAMP_DN &&  at_min: xu_d = 1'b1;
                    default: ;
                endcase
            end
        end else if (run) begin
            // simultaneous requests cancel each other
            xu_d = req_up & ~req_dn & ~at_max;
            xd_d = req_dn & ~req_up & ~at_min;
        end
        if (xu_d) begin
            step_d = step_q + SW'(1);
        end else if (xd_d) begin
            step_d = step_q - SW'(1);
        end
        ena_d  = run;
        conf_d = run ? conf_q : conf_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= '0;
            s2_q    <= '0;
            db_q    <= '0;
            dbp_q   <= '0;
            cnt_q   <= '0;
            presc_q <= '0;
            step_q  <= '0;
            xu_q    <= 1'b0;
            xd_q    <= 1'b0;
            ena_q   <= 1'b0;
            conf_q  <= '0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            db_q    <= db_d;
            dbp_q   <= dbp_d;
            cnt_q   <= cnt_d;
            presc_q <= presc_d;
            step_q  <= step_d;
            xu_q    <= xu_d;
            xd_q    <= xd_d;
            ena_q   <= ena_d;
            conf_q  <= conf_d;
        end
    end

    assign xu_o      = xu_q;
    assign xd_o      = xd_q;
    assign ena_o     = ena_q;
    assign conf_o    = conf_q;
    assign duty_step = step_q;

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Directed bench for pwm_duty_sequencer with DB_CYCLES=4,
// SWEEP_DIV=8, STEPS=10: latency, debounce, saturation, sweep, reset.
module tb_pwm_duty_sequencer;
    localparam int SW = 4;

    logic          clk;
    logic          rst;
    logic          btn_up;
    logic          btn_dn;
    logic          mode_auto;
    logic          run;
    logic [2:0]    conf_in;
    logic          xu_o;
    logic          xd_o;
    logic          ena_o;
    logic [2:0]    conf_o;
    logic [SW-1:0] duty_step;
    logic          sweep_dir;

    int n_assert = 0;
    int n_fail   = 0;
    int n_xu     = 0;
    int n_xd     = 0;
    logic prev_xu = 1'b0;
    logic prev_xd = 1'b0;

    pwm_duty_sequencer #(
        .DB_CYCLES(4),
        .SWEEP_DIV(8),
        .STEPS    (10),
        .SW       (SW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_up   (btn_up),
        .btn_dn   (btn_dn),
        .mode_auto(mode_auto),
        .run      (run),
        .conf_in  (conf_in),
        .xu_o     (xu_o),
        .xd_o     (xd_o),
        .ena_o    (ena_o),
        .conf_o   (conf_o),
        .duty_step(duty_step),
        .sweep_dir(sweep_dir)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // pulse counting plus exclusivity / single-cycle width
    always @(negedge clk) begin
        n_assert++;
        assert (!(xu_o && xd_o)) else begin
            n_fail++;
            $error("FAIL excl: observed xu=%0b xd=%0b expected not both", xu_o, xd_o);
        end
        n_assert++;
        assert (!((xu_o && prev_xu) || (xd_o && prev_xd))) else begin
            n_fail++;
            $error("FAIL width: observed xu=%0b xd=%0b after xu=%0b xd=%0b expected 1-cycle pulses",
                   xu_o, xd_o, prev_xu, prev_xd);
        end
        if (xu_o) n_xu++;
        if (xd_o) n_xd++;
        prev_xu = xu_o;
        prev_xd = xd_o;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic press(input bit dn);
        if (dn) btn_dn = 1'b1;
        else btn_up = 1'b1;
        cyc(8);
        btn_up = 1'b0;
        btn_dn = 1'b0;
        cyc(8);
    endtask

    initial begin
        int bu, bd, d;
        logic eu, ed;
        rst = 1'b1; btn_up = 1'b0; btn_dn = 1'b0;
        mode_auto = 1'b0; run = 1'b0; conf_in = 3'd3;
        cyc(3);
        chk("rst_xu", 32'(xu_o), 32'(0));
        chk("rst_xd", 32'(xd_o), 32'(0));
        chk("rst_ena", 32'(ena_o), 32'(0));
        chk("rst_conf", 32'(conf_o), 32'(0));
        chk("rst_duty", 32'(duty_step), 32'(0));
        chk("rst_dir", 32'(sweep_dir), 32'(0));

        rst = 1'b0;
        cyc(1);
        chk("conf_track", 32'(conf_o), 32'(3));
        chk("ena_off", 32'(ena_o), 32'(0));
        run = 1'b1; conf_in = 3'd6;
        cyc(1);
        chk("ena_on", 32'(ena_o), 32'(1));
        chk("conf_frozen", 32'(conf_o), 32'(3));

        bu = n_xu;
        btn_up = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            cyc(1);
            chk("lat_xu", 32'(xu_o), 32'(i == 7));
        end
        chk("lat_duty", 32'(duty_step), 32'(1));
        btn_up = 1'b0;
        cyc(10);
        chk("lat_count", 32'(n_xu - bu), 32'(1));

        bu = n_xu;
        btn_up = 1'b1; cyc(1);
        btn_up = 1'b0; cyc(1);
        btn_up = 1'b1; cyc(14);
        chk("bounce_count", 32'(n_xu - bu), 32'(1));
        chk("bounce_duty", 32'(duty_step), 32'(2));
        btn_up = 1'b0;
        cyc(10);
        bu = n_xu;
        btn_up = 1'b1; cyc(3);
        btn_up = 1'b0; cyc(12);
        chk("glitch_count", 32'(n_xu - bu), 32'(0));
        chk("glitch_duty", 32'(duty_step), 32'(2));

        rst = 1'b1; cyc(1);
        rst = 1'b0;
        chk("rst2_duty", 32'(duty_step), 32'(0));
        bu = n_xu; bd = n_xd;
        repeat (12) press(1'b0);
        chk("sat_up_xu", 32'(n_xu - bu), 32'(10));
        chk("sat_up_xd", 32'(n_xd - bd), 32'(0));
        chk("sat_up_duty", 32'(duty_step), 32'(10));
        repeat (11) press(1'b1);
        chk("sat_dn_xd", 32'(n_xd - bd), 32'(10));
        chk("sat_dn_xu", 32'(n_xu - bu), 32'(10));
        chk("sat_dn_duty", 32'(duty_step), 32'(0));

        bu = n_xu; bd = n_xd;
        btn_up = 1'b1; btn_dn = 1'b1;
        cyc(10);
        chk("both_xu", 32'(n_xu - bu), 32'(0));
        chk("both_xd", 32'(n_xd - bd), 32'(0));
        chk("both_duty", 32'(duty_step), 32'(0));
        btn_up = 1'b0; btn_dn = 1'b0;
        cyc(10);

        d = 0;
        mode_auto = 1'b1;
        for (int i = 1; i <= 170; i++) begin
            cyc(1);
            eu = (i >= 9) && (i % 8 == 1) && (i <= 81 || i == 169);
            ed = (i % 8 == 1) && (i >= 89) && (i <= 161);
            if (eu) d++;
            if (ed) d--;
            chk("auto_xu", 32'(xu_o), 32'(eu));
            chk("auto_xd", 32'(xd_o), 32'(ed));
            chk("auto_duty", 32'(duty_step), 32'(d));
            chk("auto_dir", 32'(sweep_dir), 32'(i >= 89 && i < 169));
        end

        run = 1'b0; conf_in = 3'd5; btn_up = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            cyc(1);
            chk("halt_ena", 32'(ena_o), 32'(0));
            chk("halt_xu", 32'(xu_o), 32'(0));
            chk("halt_xd", 32'(xd_o), 32'(0));
            chk("halt_duty", 32'(duty_step), 32'(1));
            chk("halt_conf", 32'(conf_o), 32'(5));
        end
        run = 1'b1; conf_in = 3'd2; btn_up = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            cyc(1);
            chk("resume_xu", 32'(xu_o), 32'(i == 9));
            chk("resume_ena", 32'(ena_o), 32'(1));
            chk("resume_conf", 32'(conf_o), 32'(5));
        end
        chk("resume_duty", 32'(duty_step), 32'(2));
        for (int i = 1; i <= 32; i++) begin
            cyc(1);
            chk("ramp6_xu", 32'(xu_o), 32'(i % 8 == 0));
        end
        chk("ramp6_duty", 32'(duty_step), 32'(6));

        rst = 1'b1;
        cyc(1);
        chk("arst_xu", 32'(xu_o), 32'(0));
        chk("arst_xd", 32'(xd_o), 32'(0));
        chk("arst_ena", 32'(ena_o), 32'(0));
        chk("arst_conf", 32'(conf_o), 32'(0));
        chk("arst_duty", 32'(duty_step), 32'(0));
        chk("arst_dir", 32'(sweep_dir), 32'(0));
        rst = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            cyc(1);
            chk("post_rst_xu", 32'(xu_o), 32'(i == 9));
        end
        chk("post_rst_duty", 32'(duty_step), 32'(1));
        chk("post_rst_conf", 32'(conf_o), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
